// File: rtl/hack_loader_pkg.sv
// Shared types and constants for the Hack program loader.
package hack_loader_pkg;
    localparam int WORD_W   = 16;
    localparam bit HI_FIRST = 1'b1;

    typedef enum logic [2:0] {
        LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, DONE, ERROR
    } ld_state_t;
endpackage

// File: rtl/hack_loader_word_asm.sv
// Byte-pair to word assembler shared by the length, data and checksum fields.
module hack_loader_word_asm
    import hack_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic              lo_phase,
    input  logic [7:0]        byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);
    logic [7:0] hi_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       hi_q <= '0;
        else if (byte_valid && !lo_phase) hi_q <= byte_data;
    end

    // Word is combinational so the FSM can act on it in the same cycle as the second byte.
    assign word       = HI_FIRST ? {hi_q, byte_data} : {byte_data, hi_q};
    assign word_valid = byte_valid && lo_phase;
endmodule

// File: rtl/hack_prog_loader.sv
// Streams a Hack image into instruction memory while holding the CPU in reset.
// Optional checksum verification: define LOADER_CHECKSUM_EN.
module hack_prog_loader
    import hack_loader_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int MAX_WORDS = 32768
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_din,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);
    ld_state_t         state, state_nxt;
    logic              accept, lo_phase, word_valid, last_word, restart;
    logic [WORD_W-1:0] word, len;
    logic [ADDR_W:0]   cnt;

`ifdef LOADER_CHECKSUM_EN
    localparam ld_state_t END_ST = CSUM_HI;
    logic [WORD_W-1:0] sum;
`else
    localparam ld_state_t END_ST = DONE;
`endif

    assign accept    = rx_valid && rx_ready;
    assign lo_phase  = (state == LEN_LO) || (state == DATA_LO) || (state == CSUM_LO);
    assign last_word = (32'(cnt) + 32'd1) == 32'(len);
    assign restart   = start && ((state == DONE) || (state == ERROR));

    hack_loader_word_asm u_asm (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (accept),
        .lo_phase   (lo_phase),
        .byte_data  (rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LEN_HI;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LEN_HI:  if (accept) state_nxt = LEN_LO;
            LEN_LO:  if (accept) begin
                if (word == '0)                  state_nxt = END_ST;
                else if (int'(word) > MAX_WORDS) state_nxt = ERROR;
                else                             state_nxt = DATA_HI;
            end
            DATA_HI: if (accept) state_nxt = DATA_LO;
            DATA_LO: if (accept) state_nxt = last_word ? END_ST : DATA_HI;
`ifdef LOADER_CHECKSUM_EN
            CSUM_HI: if (accept) state_nxt = CSUM_LO;
            CSUM_LO: if (accept) state_nxt = (word == sum) ? DONE : ERROR;
`endif
            DONE, ERROR: if (start) state_nxt = LEN_HI;
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            DONE:    begin rx_ready = 1'b0; cpu_hold = 1'b0; done = 1'b1; end
            ERROR:   begin rx_ready = 1'b0; error = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            len       <= '0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_din  <= '0;
        end else begin
            imem_we <= 1'b0;
            if (restart) cnt <= '0;
            if (state == LEN_LO && word_valid) len <= word;
            if (state == DATA_LO && word_valid) begin
                imem_we   <= 1'b1;
                imem_din  <= word;
                imem_addr <= cnt[ADDR_W-1:0];
                cnt       <= cnt + 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                sum <= '0;
        else if (restart)                         sum <= '0;
        else if (state == DATA_LO && word_valid)  sum <= sum + word;
    end
`endif
endmodule

// File: tb/tb_hack_prog_loader.sv
// Directed bench for hack_prog_loader; checksum cases are built when LOADER_CHECKSUM_EN is defined.
module tb_hack_prog_loader;
    logic        clk = 1'b0;
    logic        reset, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready, imem_we, cpu_hold, done, error;
    logic [14:0] imem_addr;
    logic [15:0] imem_din;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [15:0] mem [0:31];
    logic [14:0] first_addr;

    hack_prog_loader #(.ADDR_W(15), .MAX_WORDS(32768)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_din(imem_din),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_cnt == 0) first_addr = imem_addr;
            mem[imem_addr[4:0]] = imem_din;
            wr_cnt++;
        end
    end

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) begin
            checks++; errors++;
            $display("FAIL send_byte_timeout: rx_ready=%b, required 1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        for (int i = 0; i < gap; i++) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_ready, imem_we, cpu_hold, done, error} !== 5'b10100 || imem_addr !== 15'd0 || imem_din !== 16'd0) begin
            errors++;
            $display("FAIL reset_values: rdy/we/hold/done/err=%b addr=%h din=%h, required 10100 0 0",
                     {rx_ready, imem_we, cpu_hold, done, error}, imem_addr, imem_din);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        logic [7:0] img [8] = '{8'h00, 8'h03, 8'hEC, 8'h10, 8'hE3, 8'h08, 8'h00, 8'h05};
        wr_cnt = 0;
        for (int i = 0; i < 8; i++) send_byte(img[i], 0);
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 15'd2 || imem_din !== 16'h0005) begin
            errors++;
            $display("FAIL basic_last_write: we=%b addr=%h din=%h, required 1 2 0005", imem_we, imem_addr, imem_din);
        end
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b hold=%b rdy=%b, required 1 0 0", done, cpu_hold, rx_ready);
        end
        @(negedge clk);
        checks++;
        if (imem_we !== 1'b0) begin
            errors++; $display("FAIL basic_we_drop: we=%b, required 0", imem_we);
        end
        checks++;
        if (wr_cnt != 3 || first_addr !== 15'd0 || mem[0] !== 16'hEC10 || mem[1] !== 16'hE308 || mem[2] !== 16'h0005) begin
            errors++;
            $display("FAIL basic_mem: writes=%0d first=%h m0=%h m1=%h m2=%h, required 3 0 EC10 E308 0005",
                     wr_cnt, first_addr, mem[0], mem[1], mem[2]);
        end
    endtask

    task automatic test_zero_len();
        pulse_start();
        wr_cnt = 0;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || wr_cnt != 0) begin
            errors++;
            $display("FAIL zero_len: done=%b hold=%b writes=%0d, required 1 0 0", done, cpu_hold, wr_cnt);
        end
    endtask

    task automatic test_oversize();
        pulse_start();
        wr_cnt = 0;
        send_byte(8'h80, 0);
        send_byte(8'h01, 0);
        checks++;
        if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL oversize: err=%b hold=%b done=%b rdy=%b, required 1 1 0 0", error, cpu_hold, done, rx_ready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wr_cnt != 0) begin
            errors++; $display("FAIL oversize_writes: writes=%0d, required 0", wr_cnt);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] img [6] = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02};
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(img[i], 0);
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0) begin
            errors++; $display("FAIL csum_match: done=%b hold=%b, required 1 0", done, cpu_hold);
        end
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(img[i], 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        checks++;
        if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL csum_mismatch: err=%b hold=%b done=%b, required 1 1 0", error, cpu_hold, done);
        end
    endtask
`endif

    task automatic test_reset_mid_load();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h03, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || imem_we !== 1'b0) begin
            errors++;
            $display("FAIL midload_reset: rdy=%b hold=%b done=%b err=%b we=%b, required 1 1 0 0 0",
                     rx_ready, cpu_hold, done, error, imem_we);
        end
        reset = 1'b0;
        @(negedge clk);
        wr_cnt = 0;
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h11, 0); send_byte(8'h11, 0);
        send_byte(8'h22, 0); send_byte(8'h22, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h33, 0); send_byte(8'h33, 0);
`endif
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || wr_cnt != 2 || first_addr !== 15'd0 || mem[0] !== 16'h1111 || mem[1] !== 16'h2222) begin
            errors++;
            $display("FAIL midload_reload: done=%b writes=%0d first=%h m0=%h m1=%h, required 1 2 0 1111 2222",
                     done, wr_cnt, first_addr, mem[0], mem[1]);
        end
    endtask

    task automatic test_gapped_restart();
        int wr_before;
        // Byte offered while in DONE must be held, not consumed.
        rx_valid = 1'b1; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1 || rx_ready !== 1'b0) begin
            errors++; $display("FAIL held_in_done: done=%b rdy=%b, required 1 0", done, rx_ready);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (cpu_hold !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b1) begin
            errors++; $display("FAIL restart: hold=%b done=%b rdy=%b, required 1 0 1", cpu_hold, done, rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        wr_cnt = 0;
        repeat (2) @(negedge clk);
        send_byte(8'h01, 2);
        send_byte(8'hAB, 2);
        wr_before = wr_cnt;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_cnt != wr_before || done !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL gap_no_consume: writes=%0d done=%b rdy=%b, required %0d 0 1", wr_cnt, done, rx_ready, wr_before);
        end
        send_byte(8'hCD, 2);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hAB, 2);
        send_byte(8'hCD, 2);
`endif
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || wr_cnt != 1 || first_addr !== 15'd0 || mem[0] !== 16'hABCD) begin
            errors++;
            $display("FAIL gapped_reload: done=%b hold=%b writes=%0d first=%h m0=%h, required 1 0 1 0 ABCD",
                     done, cpu_hold, wr_cnt, first_addr, mem[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'hDEAD;
        first_addr = '1;
        test_reset();
        test_basic_load();
        test_zero_len();
        test_oversize();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_load();
        test_gapped_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
